i2s_frame_scheduler: RTL and testbench

Collects the 16-bit unsigned samples produced by the I2S receiver into fixed-length analysis frames in a two-bank ping-pong buffer. It hands each completed frame to the downstream pitch-analysis block as a valid/ready stream. The block arbitrates the buffer between the sample producer (write side) and the frame consumer (read side), and reports frames dropped when the consumer falls behind.

---
 rtl/audio_pkg.sv | 13 +
 rtl/frame_bank_ram.sv | 26 ++
 rtl/i2s_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2s_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants and the frame scheduler read-FSM state encoding.
package audio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned FRAME_WINDOW = 512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port, no array reset
// so it maps onto block RAM.
module frame_bank_ram #(
  parameter int unsigned WINDOW = 512,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(WINDOW):0]  wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(WINDOW):0]  rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int unsigned DEPTH = 2 * WINDOW;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Ping-pong frame collector: packs incoming samples into WINDOW-long frames and
// streams completed frames out over valid/ready, counting frames it had to drop.
module i2s_frame_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned WINDOW = FRAME_WINDOW,
  parameter int unsigned WIDTH  = SAMPLE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid_in,
  output logic [WIDTH-1:0] frame_data_out,
  output logic             frame_valid_out,
  output logic             frame_last_out,
  input  logic             frame_ready_in,
  output logic             overrun_out,
  output logic [7:0]       drop_count_out
);

  localparam int unsigned  AW        = $clog2(WINDOW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WINDOW - 1);

  logic            wbank;
  logic [AW-1:0]   waddr;
  logic            wskip;
  logic [1:0]      full;
  rd_state_e       state;
  logic            rbank;
  logic [AW-1:0]   raddr;

  logic            smp_wr;
  logic            wr_done;
  logic            xfer;
  logic            release_bank;
  logic            blocked;
  logic            drop;
  logic            handoff;
  logic            ram_we;
  logic [AW:0]     ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;

  // A release on the last beat is applied before the writer's full check.
  always_comb begin
    smp_wr       = sample_valid_in && enable_in;
    wr_done      = smp_wr && (waddr == LAST_ADDR);
    xfer         = frame_valid_out && frame_ready_in;
    release_bank = xfer && frame_last_out;
    blocked      = full[wbank] && !(release_bank && (rbank == wbank));
    ram_we       = smp_wr && !blocked && !wskip;
    drop         = wr_done && (blocked || wskip);
    handoff      = wr_done && !drop;

    ram_rd_addr = {rbank, raddr};
    unique case (state)
      IDLE:     ram_rd_addr = {~full[0], AW'(0)};
      PREFETCH: ram_rd_addr = {rbank, AW'(1)};
      STREAM:   ram_rd_addr = {rbank, xfer ? raddr + AW'(1) : raddr};
      default:  ram_rd_addr = {rbank, raddr};
    endcase
  end

  frame_bank_ram #(
    .WINDOW (WINDOW),
    .WIDTH  (WIDTH)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (ram_we),
    .wr_addr ({wbank, waddr}),
    .wr_data (sample_in),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Write side: a frame that started while its bank was still held is discarded whole.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wbank          <= 1'b0;
      waddr          <= '0;
      wskip          <= 1'b0;
      full           <= 2'b00;
      overrun_out    <= 1'b0;
      drop_count_out <= 8'd0;
    end else begin
      if (release_bank) begin
        full[rbank] <= 1'b0;
      end
      if (!enable_in) begin
        waddr <= '0;
        wskip <= 1'b0;
      end else if (smp_wr) begin
        waddr <= waddr + AW'(1);
        if (wr_done) begin
          wskip <= 1'b0;
        end else if (blocked) begin
          wskip <= 1'b1;
        end
        if (handoff) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      overrun_out <= drop;
      if (drop && (drop_count_out != 8'hFF)) begin
        drop_count_out <= drop_count_out + 8'd1;
      end
    end
  end

  // Read FSM: frame_data_out trails the RAM register by one beat, raddr points at the RAM word.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      rbank           <= 1'b0;
      raddr           <= '0;
      frame_valid_out <= 1'b0;
      frame_last_out  <= 1'b0;
      frame_data_out  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|full) begin
            rbank <= ~full[0];
            raddr <= '0;
            state <= PREFETCH;
          end
        end
        PREFETCH: begin
          frame_data_out  <= ram_rd_data;
          frame_valid_out <= 1'b1;
          frame_last_out  <= 1'b0;
          raddr           <= AW'(1);
          state           <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (frame_last_out) begin
              frame_valid_out <= 1'b0;
              frame_last_out  <= 1'b0;
              state           <= IDLE;
            end else begin
              frame_data_out <= ram_rd_data;
              frame_last_out <= (raddr == LAST_ADDR);
              raddr          <= raddr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler with an 8-sample window.
module tb_i2s_frame_scheduler;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned WIDTH  = 16;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             enable_in = 1'b1;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid_in = 1'b0;
  logic [WIDTH-1:0] frame_data_out;
  logic             frame_valid_out;
  logic             frame_last_out;
  logic             frame_ready_in = 1'b0;
  logic             overrun_out;
  logic [7:0]       drop_count_out;

  int vectors = 0;
  int miscompares = 0;

  i2s_frame_scheduler #(
    .WINDOW (WINDOW),
    .WIDTH  (WIDTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .enable_in       (enable_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .frame_data_out  (frame_data_out),
    .frame_valid_out (frame_valid_out),
    .frame_last_out  (frame_last_out),
    .frame_ready_in  (frame_ready_in),
    .overrun_out     (overrun_out),
    .drop_count_out  (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Called at a falling edge; presents one sample for the next rising edge.
  task automatic push(input logic [WIDTH-1:0] v);
    sample_in       = v;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (frame_valid_out !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    ok = (frame_valid_out === 1'b1);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", frame_valid_out); end
    vectors++; if (frame_last_out !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", frame_last_out); end
    vectors++; if (frame_data_out !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %0d want 0", frame_data_out); end
    vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
    vectors++; if (drop_count_out !== 8'd0) begin miscompares++; $display("FAIL reset_drops: got %0d want 0", drop_count_out); end
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_basic_frame();
    logic exp_last;
    frame_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(i));
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_lat_t0: valid got %b want 0", frame_valid_out); end
    @(negedge clk_in);
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_lat_t1: valid got %b want 0", frame_valid_out); end
    @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      exp_last = (i == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(i) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, frame_valid_out, frame_data_out, frame_last_out, i, exp_last);
      end
      @(negedge clk_in);
    end
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_end: valid got %b want 0", frame_valid_out); end
  endtask

  task automatic test_stall();
    bit ok;
    int idx = 0;
    logic [3:0] pat = 4'b1001;
    logic exp_last;
    frame_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push(16'(100 + i));
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout: valid got %b want 1", frame_valid_out); end
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      exp_last = (idx == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(100 + idx) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL stall_beat%0d_cyc%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", idx, cyc, frame_valid_out, frame_data_out, frame_last_out, 100 + idx, exp_last);
      end
      frame_ready_in = pat[cyc % 4];
      if (frame_ready_in) idx++;
      @(negedge clk_in);
    end
    frame_ready_in = 1'b0;
    vectors++;
    if (idx != 8 || frame_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: beats=%0d valid=%b want beats=8 valid=0", idx, frame_valid_out);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic exp_pulse;
    logic exp_last;
    frame_ready_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      push(16'(i));
      exp_pulse = (i == 23);
      vectors++; if (overrun_out !== exp_pulse) begin miscompares++; $display("FAIL overrun_pulse_s%0d: got %b want %b", i, overrun_out, exp_pulse); end
    end
    @(negedge clk_in);
    vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL overrun_width: got %b want 0", overrun_out); end
    vectors++; if (drop_count_out !== 8'd1) begin miscompares++; $display("FAIL overrun_count: got %0d want 1", drop_count_out); end
    frame_ready_in = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_valid(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL overrun_timeout_f%0d: valid got %b want 1", f, frame_valid_out); end
      for (int i = 0; i < 8; i++) begin
        exp_last = (i == 7);
        vectors++;
        if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(8 * f + i) || frame_last_out !== exp_last) begin
          miscompares++;
          $display("FAIL overrun_f%0d_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", f, i, frame_valid_out, frame_data_out, frame_last_out, 8 * f + i, exp_last);
        end
        @(negedge clk_in);
      end
    end
    repeat (4) @(negedge clk_in);
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL overrun_no_third: valid got %b want 0", frame_valid_out); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic exp_last;
    frame_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push(16'(200 + i));
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL simul_timeout_a: valid got %b want 1", frame_valid_out); end
    // Beat j of this frame and sample j of the next share a rising edge.
    for (int j = 0; j < 8; j++) begin
      exp_last = (j == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(200 + j) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL simul_a_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", j, frame_valid_out, frame_data_out, frame_last_out, 200 + j, exp_last);
      end
      sample_in       = 16'(210 + j);
      sample_valid_in = 1'b1;
      frame_ready_in  = 1'b1;
      @(negedge clk_in);
      vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL simul_overrun_c%0d: got %b want 0", j, overrun_out); end
    end
    sample_valid_in = 1'b0;
    vectors++; if (drop_count_out !== 8'd1) begin miscompares++; $display("FAIL simul_count: got %0d want 1", drop_count_out); end
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL simul_timeout_b: valid got %b want 1", frame_valid_out); end
    for (int i = 0; i < 8; i++) begin
      exp_last = (i == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(210 + i) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL simul_b_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, frame_valid_out, frame_data_out, frame_last_out, 210 + i, exp_last);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_enable();
    bit ok;
    logic exp_last;
    frame_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) push(16'(300 + i));
    enable_in = 1'b0;
    push(16'd999);
    @(negedge clk_in);
    enable_in = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(310 + i));
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL enable_timeout: valid got %b want 1", frame_valid_out); end
    for (int i = 0; i < 8; i++) begin
      exp_last = (i == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(310 + i) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL enable_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, frame_valid_out, frame_data_out, frame_last_out, 310 + i, exp_last);
      end
      @(negedge clk_in);
    end
    repeat (6) @(negedge clk_in);
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL enable_single_frame: valid got %b want 0", frame_valid_out); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic exp_last;
    frame_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(400 + i));
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout_a: valid got %b want 1", frame_valid_out); end
    repeat (3) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", frame_valid_out); end
    vectors++; if (frame_last_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_last: got %b want 0", frame_last_out); end
    vectors++; if (frame_data_out !== 16'd0) begin miscompares++; $display("FAIL rstmid_data: got %0d want 0", frame_data_out); end
    vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun: got %b want 0", overrun_out); end
    vectors++; if (drop_count_out !== 8'd0) begin miscompares++; $display("FAIL rstmid_drops: got %0d want 0", drop_count_out); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 8; i++) push(16'(500 + i));
    wait_valid(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout_b: valid got %b want 1", frame_valid_out); end
    for (int i = 0; i < 8; i++) begin
      exp_last = (i == 7);
      vectors++;
      if (frame_valid_out !== 1'b1 || frame_data_out !== 16'(500 + i) || frame_last_out !== exp_last) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, frame_valid_out, frame_data_out, frame_last_out, 500 + i, exp_last);
      end
      @(negedge clk_in);
    end
    vectors++; if (frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_end: valid got %b want 0", frame_valid_out); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk_in);
    test_reset();
    test_basic_frame();
    test_stall();
    test_overrun();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
